// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_pkg
//  Description : Shared constants and helpers for the 5-stage ARM pipeline.
//                ADDR_W / INSTR_W   : default datapath widths
//                NOP_INSTR          : MOV r0,r0, inserted on flush/reset
//                PC_STEP            : sequential fetch increment
//                sat_inc()          : saturating increment for stat counters
//  Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

    localparam int          ADDR_W    = 32;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;
    localparam int          PC_STEP   = 4;

    // Counters of any width up to 32 bits pass through here zero-extended;
    // the caller truncates the result back to its own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage : arm_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bus bundle of the instruction-fetch stage.
//                slave  modport : fetch unit side
//                master modport : pipeline / memory / testbench side
//                Control in : freezeIn, branchTakenIn, branchAddrIn
//                Memory     : imemAddrOut (out), imemDataIn (in)
//                IF/ID      : pcOut, instrOut, validOut
//                Statistics : stallCountOut, flushCountOut
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if
    import arm_pkg::*;
#(
    parameter int ADDR_W  = arm_pkg::ADDR_W,
    parameter int INSTR_W = arm_pkg::INSTR_W,
    parameter int CNT_W   = 16
) ();

    logic               freezeIn;
    logic               branchTakenIn;
    logic [ADDR_W-1:0]  branchAddrIn;
    logic [ADDR_W-1:0]  imemAddrOut;
    logic [INSTR_W-1:0] imemDataIn;
    logic [ADDR_W-1:0]  pcOut;
    logic [INSTR_W-1:0] instrOut;
    logic               validOut;
    logic [CNT_W-1:0]   stallCountOut;
    logic [CNT_W-1:0]   flushCountOut;

    modport slave (
        input  freezeIn, branchTakenIn, branchAddrIn, imemDataIn,
        output imemAddrOut, pcOut, instrOut, validOut,
               stallCountOut, flushCountOut
    );

    modport master (
        output freezeIn, branchTakenIn, branchAddrIn, imemDataIn,
        input  imemAddrOut, pcOut, instrOut, validOut,
               stallCountOut, flushCountOut
    );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register with synchronous reset, hold and
//                flush. Reset and flush both load the bubble (NOP, pc 0,
//                invalid); hold keeps the current contents.
//                clk, rst      : clock, synchronous active-high reset
//                i_hold        : keep current contents (freeze)
//                i_flush       : load a bubble (wins over i_hold)
//                i_pc, i_instr : next PC field / instruction word
//                o_pc, o_instr, o_valid : registered IF/ID fields
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import arm_pkg::*;
#(
    parameter int                 ADDR_W    = arm_pkg::ADDR_W,
    parameter int                 INSTR_W   = arm_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(arm_pkg::NOP_INSTR)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_hold,
    input  wire logic               i_flush,
    input  wire logic [ADDR_W-1:0]  i_pc,
    input  wire logic [INSTR_W-1:0] i_instr,
    output logic      [ADDR_W-1:0]  o_pc,
    output logic      [INSTR_W-1:0] o_instr,
    output logic                    o_valid
);

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Holds the PC, drives the
//                instruction-memory address, registers the fetched word into
//                IF/ID and keeps saturating stall/flush statistics.
//                Priority per edge: reset > branch > freeze > normal fetch.
//                clkIn, rstIn : clock, synchronous active-high reset
//                bus          : fetch_unit_if.slave (control, imem, IF/ID,
//                               statistics)
//                Interface parameters must match ADDR_W/INSTR_W/CNT_W here.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import arm_pkg::*;
#(
    parameter int                 ADDR_W    = arm_pkg::ADDR_W,
    parameter int                 INSTR_W   = arm_pkg::INSTR_W,
    parameter int                 CNT_W     = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(arm_pkg::NOP_INSTR)
) (
    input wire logic     clkIn,
    input wire logic     rstIn,
    fetch_unit_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_pc_step   = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] c_align_msk = ~ADDR_W'(3);
    // All-ones of a CNT_W counter, widened to the helper's 32-bit domain.
    localparam logic [31:0]       c_cnt_max   = 32'((64'd1 << CNT_W) - 64'd1);

    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_target;

    // Natural modulo-2^ADDR_W wrap is intended; no overflow flag.
    assign w_pc_plus4 = r_pc + c_pc_step;
    assign w_target   = bus.branchAddrIn & c_align_msk;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_pc <= RESET_PC;
        end else if (bus.branchTakenIn) begin
            r_pc <= w_target;
        end else if (!bus.freezeIn) begin
            r_pc <= w_pc_plus4;
        end
    end

    // A branch during a freeze counts only as a flush: the bubble replaces
    // the frozen instruction, so no hold cycle actually happens.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (bus.branchTakenIn) begin
            r_flush_cnt <= CNT_W'(sat_inc(32'(r_flush_cnt), c_cnt_max));
        end else if (bus.freezeIn) begin
            r_stall_cnt <= CNT_W'(sat_inc(32'(r_stall_cnt), c_cnt_max));
        end
    end

    if_id_reg #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk     (clkIn),
        .rst     (rstIn),
        .i_hold  (bus.freezeIn),
        .i_flush (bus.branchTakenIn),
        .i_pc    (w_pc_plus4),
        .i_instr (bus.imemDataIn),
        .o_pc    (bus.pcOut),
        .o_instr (bus.instrOut),
        .o_valid (bus.validOut)
    );

    assign bus.imemAddrOut   = r_pc;
    assign bus.stallCountOut = r_stall_cnt;
    assign bus.flushCountOut = r_flush_cnt;

endmodule : fetch_unit
`default_nettype wire
